// File: rtl/s1_exe_stage.sv
// Execute stage of the S1 pipeline: operand forwarding, ALU, branch/jump resolution
// and the EX/MEM pipeline register.
module s1_exe_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clk_en,
    input  logic        forward,
    input  logic [4:0]  rd_addr,
    input  logic [31:0] write_in,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    input  logic [31:0] inst_in,
    input  logic [29:0] pc_in,
    input  logic [11:0] control_word_in,
    output logic [31:0] alu_out,
    output logic [31:0] to_mem,
    output logic [31:0] inst_out,
    output logic [29:0] to_pc,
    output logic [29:0] ip_buffer_out,
    output logic [2:0]  write_back_lines,
    output logic        jmp,
    output logic        mem_req,
    output logic        mem_we
);

    logic [4:0]  rs1_idx;
    logic [4:0]  rs2_idx;
    logic [3:0]  funct4;
    logic [1:0]  b_sel;
    logic [1:0]  alu_op;
    logic [1:0]  wb_sel;
    logic        is_jump;
    logic        is_branch;

    logic [31:0] i_imm;
    logic [31:0] u_imm;
    logic [29:0] b_off;

    logic [31:0] op_a;
    logic [31:0] op_rs2;
    logic [31:0] op_b;
    logic [31:0] alu_res;
    logic [31:0] jump_sum;
    logic [29:0] pc_plus1;
    logic        branch_cond;
    logic        taken;
    logic [29:0] next_pc;
    logic [31:0] next_alu;
    logic        unused_bits;

    assign rs1_idx   = inst_in[16:12];
    assign rs2_idx   = inst_in[21:17];
    assign funct4    = inst_in[25:22];
    assign b_sel     = control_word_in[11:10];
    assign is_jump   = control_word_in[9];
    assign is_branch = control_word_in[8];
    assign alu_op    = control_word_in[6:5];
    assign wb_sel    = control_word_in[2:1];

    assign i_imm = {{17{inst_in[31]}}, inst_in[31:17]};
    assign u_imm = {inst_in[31:12], 12'b0};
    assign b_off = {{15{inst_in[31]}}, inst_in[31:22], inst_in[11:7]};

    // Register 0 is never a valid forwarding destination.
    assign op_a   = (forward && rd_addr != 5'd0 && rd_addr == rs1_idx) ? write_in : rs1;
    assign op_rs2 = (forward && rd_addr != 5'd0 && rd_addr == rs2_idx) ? write_in : rs2;

    always_comb begin
        case (b_sel)
            2'b01:   op_b = i_imm;
            2'b10:   op_b = u_imm;
            default: op_b = op_rs2;
        endcase
    end

    always_comb begin
        alu_res = op_a + op_b;
        case (alu_op)
            2'b00: alu_res = op_a + op_b;
            2'b10: alu_res = op_a - op_b;
            2'b11: alu_res = op_b;
            default: begin
                case (funct4)
                    4'd1:    alu_res = op_a - op_b;
                    4'd2:    alu_res = op_a & op_b;
                    4'd3:    alu_res = op_a | op_b;
                    4'd4:    alu_res = op_a ^ op_b;
                    4'd5:    alu_res = op_a << op_b[4:0];
                    4'd6:    alu_res = op_a >> op_b[4:0];
                    4'd7:    alu_res = $signed(op_a) >>> op_b[4:0];
                    4'd8:    alu_res = {31'b0, $signed(op_a) < $signed(op_b)};
                    4'd9:    alu_res = {31'b0, op_a < op_b};
                    default: alu_res = op_a + op_b;
                endcase
            end
        endcase
    end

    // Branches always compare against the register operand, even when B is an immediate.
    always_comb begin
        case (funct4[2:0])
            3'd0:    branch_cond = (op_a == op_rs2);
            3'd1:    branch_cond = (op_a != op_rs2);
            3'd2:    branch_cond = ($signed(op_a) <  $signed(op_rs2));
            3'd3:    branch_cond = ($signed(op_a) >= $signed(op_rs2));
            3'd4:    branch_cond = (op_a <  op_rs2);
            3'd5:    branch_cond = (op_a >= op_rs2);
            default: branch_cond = 1'b0;
        endcase
    end

    assign jump_sum = op_a + i_imm;
    assign pc_plus1 = pc_in + 30'd1;
    assign taken    = is_jump | (is_branch & branch_cond);

    always_comb begin
        next_pc = pc_plus1;
        if (is_jump)
            next_pc = jump_sum[31:2];
        else if (taken)
            next_pc = pc_in + b_off;
    end

    assign next_alu = (wb_sel == 2'b10) ? {pc_plus1, 2'b00} : alu_res;

    assign unused_bits = &{1'b0, inst_in[6:0], control_word_in[0], jump_sum[1:0]};

    // EX/MEM pipeline register; a stall simply freezes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_out          <= '0;
            to_mem           <= '0;
            inst_out         <= '0;
            to_pc            <= '0;
            ip_buffer_out    <= '0;
            write_back_lines <= '0;
            jmp              <= 1'b0;
            mem_req          <= 1'b0;
            mem_we           <= 1'b0;
        end else if (clk_en) begin
            alu_out          <= next_alu;
            to_mem           <= op_rs2;
            inst_out         <= inst_in;
            to_pc            <= next_pc;
            ip_buffer_out    <= pc_in;
            write_back_lines <= {control_word_in[3], wb_sel};
            jmp              <= taken;
            mem_req          <= control_word_in[4];
            mem_we           <= control_word_in[7];
        end
    end

endmodule

// File: tb/tb_s1_exe_stage.sv
// Self-checking bench for s1_exe_stage: directed vector table, stall/reset sequence
// and randomized traffic compared against a behavioural model.
module tb_s1_exe_stage;

    typedef struct packed {
        logic        forward;
        logic [4:0]  rd_addr;
        logic [31:0] write_in;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] inst;
        logic [29:0] pc;
        logic [11:0] ctrl;
    } in_t;

    typedef struct packed {
        logic [31:0] alu_out;
        logic [31:0] to_mem;
        logic [31:0] inst_out;
        logic [29:0] to_pc;
        logic [29:0] ip_buf;
        logic [2:0]  wbl;
        logic        jmp;
        logic        mem_req;
        logic        mem_we;
    } out_t;

    typedef struct {
        string       name;
        in_t         in;
        logic [31:0] alu_out;
        logic [31:0] to_mem;
        logic [29:0] to_pc;
        logic [2:0]  wbl;
        logic        jmp;
        logic        mem_req;
        logic        mem_we;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clk_en;
    logic        forward;
    logic [4:0]  rd_addr;
    logic [31:0] write_in;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] inst_in;
    logic [29:0] pc_in;
    logic [11:0] control_word_in;
    logic [31:0] alu_out;
    logic [31:0] to_mem;
    logic [31:0] inst_out;
    logic [29:0] to_pc;
    logic [29:0] ip_buffer_out;
    logic [2:0]  write_back_lines;
    logic        jmp;
    logic        mem_req;
    logic        mem_we;

    int checks = 0;
    int passes = 0;

    s1_exe_stage dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .clk_en           (clk_en),
        .forward          (forward),
        .rd_addr          (rd_addr),
        .write_in         (write_in),
        .rs1              (rs1),
        .rs2              (rs2),
        .inst_in          (inst_in),
        .pc_in            (pc_in),
        .control_word_in  (control_word_in),
        .alu_out          (alu_out),
        .to_mem           (to_mem),
        .inst_out         (inst_out),
        .to_pc            (to_pc),
        .ip_buffer_out    (ip_buffer_out),
        .write_back_lines (write_back_lines),
        .jmp              (jmp),
        .mem_req          (mem_req),
        .mem_we           (mem_we)
    );

    always #5 clk = ~clk;

    // Behavioural model: what the stage should capture for one instruction.
    function automatic out_t model(in_t v);
        out_t             o;
        logic [31:0]      a, r2, b, r, i_imm, u_imm;
        logic signed [14:0] off15;
        logic [3:0]       f;
        bit               take;
        int               sa, sb;
        a  = (v.forward && v.rd_addr != 0 && v.rd_addr == v.inst[16:12]) ? v.write_in : v.rs1;
        r2 = (v.forward && v.rd_addr != 0 && v.rd_addr == v.inst[21:17]) ? v.write_in : v.rs2;
        i_imm = 32'(int'($signed(v.inst[31:17])));
        u_imm = {v.inst[31:12], 12'h000};
        off15 = {v.inst[31:22], v.inst[11:7]};
        f  = v.inst[25:22];
        sa = int'(a);
        sb = int'(r2);
        case (v.ctrl[11:10])
            2'b01:   b = i_imm;
            2'b10:   b = u_imm;
            default: b = r2;
        endcase
        case (v.ctrl[6:5])
            2'b00: r = a + b;
            2'b10: r = a - b;
            2'b11: r = b;
            default: begin
                case (f)
                    4'd1: r = a - b;
                    4'd2: r = a & b;
                    4'd3: r = a | b;
                    4'd4: r = a ^ b;
                    4'd5: r = a << b[4:0];
                    4'd6: r = a >> b[4:0];
                    4'd7: r = 32'(int'(a) >>> b[4:0]);
                    4'd8: r = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
                    4'd9: r = (a < b) ? 32'd1 : 32'd0;
                    default: r = a + b;
                endcase
            end
        endcase
        case (f[2:0])
            3'd0:    take = (a == r2);
            3'd1:    take = (a != r2);
            3'd2:    take = (sa < sb);
            3'd3:    take = (sa >= sb);
            3'd4:    take = (a < r2);
            3'd5:    take = (a >= r2);
            default: take = 1'b0;
        endcase
        o.to_pc = v.pc + 30'd1;
        o.jmp   = 1'b0;
        if (v.ctrl[9]) begin
            o.jmp   = 1'b1;
            o.to_pc = 30'((a + i_imm) >> 2);
        end else if (v.ctrl[8] && take) begin
            o.jmp   = 1'b1;
            o.to_pc = 30'(int'(v.pc) + int'(off15));
        end
        o.alu_out  = (v.ctrl[2:1] == 2'b10) ? {v.pc + 30'd1, 2'b00} : r;
        o.to_mem   = r2;
        o.inst_out = v.inst;
        o.ip_buf   = v.pc;
        o.wbl      = v.ctrl[3:1];
        o.mem_req  = v.ctrl[4];
        o.mem_we   = v.ctrl[7];
        return o;
    endfunction

    task automatic apply_stimulus(input in_t v, input logic en);
        clk_en          = en;
        forward         = v.forward;
        rd_addr         = v.rd_addr;
        write_in        = v.write_in;
        rs1             = v.rs1;
        rs2             = v.rs2;
        inst_in         = v.inst;
        pc_in           = v.pc;
        control_word_in = v.ctrl;
    endtask

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp)
            passes++;
        else
            $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic compare_all(input string tag, input out_t e);
        check_output({tag, ".alu_out"},  alu_out,                  e.alu_out);
        check_output({tag, ".to_mem"},   to_mem,                   e.to_mem);
        check_output({tag, ".inst_out"}, inst_out,                 e.inst_out);
        check_output({tag, ".to_pc"},    {2'b0, to_pc},            {2'b0, e.to_pc});
        check_output({tag, ".ip_buf"},   {2'b0, ip_buffer_out},    {2'b0, e.ip_buf});
        check_output({tag, ".wbl"},      {29'b0, write_back_lines}, {29'b0, e.wbl});
        check_output({tag, ".jmp"},      {31'b0, jmp},             {31'b0, e.jmp});
        check_output({tag, ".mem_req"},  {31'b0, mem_req},         {31'b0, e.mem_req});
        check_output({tag, ".mem_we"},   {31'b0, mem_we},          {31'b0, e.mem_we});
    endtask

    function automatic in_t random_input();
        in_t v;
        v.forward  = 1'($urandom_range(0, 1));
        v.rd_addr  = 5'($urandom_range(0, 31));
        v.write_in = $urandom;
        v.rs1      = $urandom;
        v.rs2      = $urandom;
        v.inst     = $urandom;
        v.pc       = 30'($urandom);
        v.ctrl     = 12'($urandom);
        if ($urandom_range(0, 1) == 1) v.inst[16:12] = v.rd_addr;
        if ($urandom_range(0, 1) == 1) v.inst[21:17] = v.rd_addr;
        if ($urandom_range(0, 3) == 0) v.rs2 = v.rs1;
        return v;
    endfunction

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t vecs[$];
        out_t e, held;
        out_t zero;
        in_t  v;
        logic en;

        zero = '0;
        //               fwd rd  write_in      rs1           rs2           inst          pc   ctrl
        vecs.push_back('{"add_f4",   '{1'b0, 5'd0, 32'd0,  32'd2,        32'd4,        32'h0000_0004, 30'd0,    12'b000000101000},
                         32'd6, 32'd4, 30'd1, 3'b100, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{"fwd_both", '{1'b1, 5'd5, 32'd10, 32'd2,        32'd4,        32'h000A_5000, 30'd0,    12'b000000101000},
                         32'd20, 32'd10, 30'd1, 3'b100, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{"fwd_rd0",  '{1'b1, 5'd0, 32'd10, 32'd2,        32'd4,        32'h000A_5000, 30'd0,    12'b000000101000},
                         32'd6, 32'd4, 30'd1, 3'b100, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{"beq_tk",   '{1'b0, 5'd0, 32'd0,  32'd7,        32'd7,        32'hFC00_0E00, 30'd1000, 12'h100},
                         32'd14, 32'd7, 30'd516, 3'b000, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{"beq_nt",   '{1'b0, 5'd0, 32'd0,  32'd7,        32'd8,        32'hFC00_0E00, 30'd1000, 12'h100},
                         32'd15, 32'd8, 30'd1001, 3'b000, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{"jal",      '{1'b0, 5'd0, 32'd0,  32'h1000,     32'h55,       32'h0010_0000, 30'd20,   12'h20C},
                         32'd84, 32'h55, 30'h402, 3'b110, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{"store",    '{1'b0, 5'd0, 32'd0,  32'h200,      32'hDEAD,     32'hFFF8_0000, 30'd40,   12'h490},
                         32'h1FC, 32'hDEAD, 30'd41, 3'b000, 1'b0, 1'b1, 1'b1});
        vecs.push_back('{"sra",      '{1'b0, 5'd0, 32'd0,  32'h8000_0000, 32'd4,       32'h01C0_0000, 30'd3,    12'h020},
                         32'hF800_0000, 32'd4, 30'd4, 3'b000, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{"sltu",     '{1'b0, 5'd0, 32'd0,  32'd1,        32'hFFFF_FFFF, 32'h0240_0000, 30'd7,   12'h020},
                         32'd1, 32'hFFFF_FFFF, 30'd8, 3'b000, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{"lui_pass", '{1'b0, 5'd0, 32'd0,  32'd9,        32'd3,        32'hABCD_E000, 30'h3FFF_FFFF, 12'h860},
                         32'hABCD_E000, 32'd3, 30'd0, 3'b000, 1'b0, 1'b0, 1'b0});

        rst_n = 1'b0;
        apply_stimulus('0, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        compare_all("reset", zero);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            apply_stimulus(vecs[i].in, 1'b1);
            @(posedge clk);
            #1;
            e          = '0;
            e.alu_out  = vecs[i].alu_out;
            e.to_mem   = vecs[i].to_mem;
            e.inst_out = vecs[i].in.inst;
            e.to_pc    = vecs[i].to_pc;
            e.ip_buf   = vecs[i].in.pc;
            e.wbl      = vecs[i].wbl;
            e.jmp      = vecs[i].jmp;
            e.mem_req  = vecs[i].mem_req;
            e.mem_we   = vecs[i].mem_we;
            compare_all(vecs[i].name, e);
            held = e;
        end

        // Stall: inputs churn but the register must freeze.
        for (int k = 0; k < 3; k++) begin
            apply_stimulus(random_input(), 1'b0);
            @(posedge clk);
            #1;
            compare_all("stall", held);
        end

        // Asynchronous reset asserted mid-stall, between edges.
        #2;
        rst_n = 1'b0;
        #1;
        compare_all("async_rst", zero);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        apply_stimulus(random_input(), 1'b0);
        @(posedge clk);
        #1;
        compare_all("post_rst_stall", zero);
        v = random_input();
        apply_stimulus(v, 1'b1);
        @(posedge clk);
        #1;
        held = model(v);
        compare_all("first_capture", held);

        // Randomized traffic with occasional stalls.
        for (int n = 0; n < 400; n++) begin
            v  = random_input();
            en = ($urandom_range(0, 3) != 0);
            apply_stimulus(v, en);
            @(posedge clk);
            #1;
            if (en) held = model(v);
            compare_all("rand", held);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
